hsid_x_scheduler: RTL and testbench
===================================

// Module: hsid_x_scheduler
// PURPOSE
//  Sequences one HSpecID-X classification run behind the register block.
//  On start: per library pixel i, per band b: reads captured word b, then library word (i*bands+b), over a word-read master.
//  Streams each pair to the MSE datapath; folds returned per-pixel MSEs into min/max value+ref.
//  Reports idle/ready/done/error/cancelled back to the register block.
// PARAMETERS
//  WORD_WIDTH         32  data/address word width
//  HSP_BANDS_WIDTH     8  width of pixel_bands / band counter
//  HSP_LIBRARY_WIDTH   8  width of library_size / pixel counter / refs
// PORTS
//  clk                  in   1    clock
//  rst                  in   1    async reset, active-high
//  start                in   1    1-cycle run request
//  clear                in   1    1-cycle cancel/clear request
//  library_size         in   HLW  pixels in library
//  pixel_bands          in   HBW  bands per pixel
//  captured_pixel_addr  in   WW   byte base of captured pixel
//  library_pixel_addr   in   WW   byte base of library
//  idle                 out  1    FSM in IDLE
//  ready                out  1    idle & !start & !clear
//  done/error/cancelled out  1    1-cycle completion pulses (mutually exclusive)
//  mem_req/mem_addr     out  1/WW read request, byte address
//  mem_gnt              in   1    request accepted this cycle
//  mem_rvalid/mem_err   in   1/1  read data valid / bus error (qualified by rvalid)
//  mem_rdata            in   WW   read data
//  dp_valid             out  1    band pair valid (datapath never stalls)
//  dp_captured/dp_library out WW  band operands
//  dp_last_band         out  1    final band of current pixel
//  dp_pixel_ref         out  HLW  current pixel index
//  dp_mse_valid         in   1    per-pixel MSE result
//  dp_mse_value/dp_mse_ref in WW/HLW  result value, pixel index
//  mse_min_ref/mse_min_value, mse_max_ref/mse_max_value  out  HLW/WW  running extrema
// BEHAVIOUR
//  - Reset: all outputs 0 except idle=1, ready=1; min_value=0, FSM=IDLE.
//  - States: IDLE, CAP_REQ, CAP_WAIT, LIB_REQ, LIB_WAIT, EMIT, DRAIN, CANCEL.
//  - IDLE+start: if library_size==0 or pixel_bands==0 -> error pulse next cycle, stay IDLE;
//    else b=0,i=0, min_value='1, max_value=0, refs=0, results=0 -> CAP_REQ.
//  - CAP_REQ: mem_req=1, addr=captured+4*b; hold req/addr stable until gnt -> CAP_WAIT.
//  - CAP_WAIT: rvalid latches captured word -> LIB_REQ (addr=library+4*(i*bands+b), mod 2^WW).
//  - LIB_WAIT: rvalid -> EMIT: dp_valid=1 for 1 cycle, dp_last_band=(b==bands-1).
//    Then b++; on last band b=0,i++; if i==library_size-1 and last band -> DRAIN else CAP_REQ.
//  - Single outstanding read; min EMIT spacing 5 cycles with gnt/rvalid 1 cycle after req.
//  - dp_mse_valid accepted in any busy state: value<min -> update min; value>max -> update max
//    (strict; ties keep lower ref); results++.
//  - DRAIN: when results==library_size -> done pulse, IDLE; outputs hold until next start/clear.
//  - mem_err on any rvalid -> error pulse, IDLE (no pending read remains).
//  - clear while busy: if read granted & not returned -> CANCEL until rvalid, else directly;
//    then cancelled pulse, IDLE. In IDLE: zeroes all mse outputs, no pulse.
//  - start+clear same cycle: clear wins. start while busy: ignored.
//  - mse outputs only change while busy or on clear/start; stable while idle.
//  - Async reset mid-run: immediate return to reset values; mem_req drops.
// STRUCTURE
//  - hsid_pkg: hsid_sched_state_e enum; HSID_WORD_BYTES=4 constant.
//  - Sub-module hsid_x_minmax: min/max value+ref tracker (init, update, clear).
// TESTING
//  - bands=3, lib=2, zero-wait mem, dp_mse 10 then 4 -> 12 reads in order, 6 dp_valid, min=4/ref1, max=10/ref0, done x1.
//  - mem_gnt delayed 3 cycles -> mem_req/mem_addr held stable, no duplicate reads.
//  - start with library_size=0 -> error pulse 1 cycle later, no mem_req.
//  - clear during CAP_WAIT (rvalid 4 cycles late) -> no new req, cancelled after rvalid, idle=1.
//  - mem_err on 2nd library read -> error pulse, idle next cycle, done never asserted.
//  - equal MSEs 7,7 -> min_ref=0, max_ref=0; start+clear together in IDLE -> no run.

Source files
------------

// File: rtl/hsid_pkg.sv
// rtl/hsid_pkg.sv - shared state encoding and constants for the HSpecID-X scheduler
package hsid_pkg;
   typedef enum logic [2:0] {
      HSID_IDLE     = 3'd0,
      HSID_CAP_REQ  = 3'd1,
      HSID_CAP_WAIT = 3'd2,
      HSID_LIB_REQ  = 3'd3,
      HSID_LIB_WAIT = 3'd4,
      HSID_EMIT     = 3'd5,
      HSID_DRAIN    = 3'd6,
      HSID_CANCEL   = 3'd7
   } hsid_sched_state_e;

   localparam int HSID_WORD_BYTES = 4;
endpackage

// File: rtl/hsid_x_scheduler_if.sv
// rtl/hsid_x_scheduler_if.sv - word-read memory master and MSE datapath links of the scheduler
interface hsid_x_scheduler_if #(
   parameter int WW  = 32,
   parameter int HLW = 8
);
   logic           mem_req;
   logic [WW-1:0]  mem_addr;
   logic           mem_gnt;
   logic           mem_rvalid;
   logic           mem_err;
   logic [WW-1:0]  mem_rdata;
   logic           dp_valid;
   logic [WW-1:0]  dp_captured;
   logic [WW-1:0]  dp_library;
   logic           dp_last_band;
   logic [HLW-1:0] dp_pixel_ref;
   logic           dp_mse_valid;
   logic [WW-1:0]  dp_mse_value;
   logic [HLW-1:0] dp_mse_ref;

   modport master (
      output mem_req, mem_addr,
      input  mem_gnt, mem_rvalid, mem_err, mem_rdata,
      output dp_valid, dp_captured, dp_library, dp_last_band, dp_pixel_ref,
      input  dp_mse_valid, dp_mse_value, dp_mse_ref
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_gnt, mem_rvalid, mem_err, mem_rdata,
      input  dp_valid, dp_captured, dp_library, dp_last_band, dp_pixel_ref,
      output dp_mse_valid, dp_mse_value, dp_mse_ref
   );
endinterface

// File: rtl/hsid_x_minmax.sv
// rtl/hsid_x_minmax.sv - running minimum/maximum MSE value and pixel reference tracker
module hsid_x_minmax #(
   parameter int WW  = 32,
   parameter int HLW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           init,
   input  logic           clr,
   input  logic           upd,
   input  logic [WW-1:0]  upd_value,
   input  logic [HLW-1:0] upd_ref,
   output logic [WW-1:0]  min_value,
   output logic [HLW-1:0] min_ref,
   output logic [WW-1:0]  max_value,
   output logic [HLW-1:0] max_ref
);
   // Strict compares: on a tie the earlier (lower) pixel reference is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_value <= '0;
         min_ref   <= '0;
         max_value <= '0;
         max_ref   <= '0;
      end else if (clr) begin
         min_value <= '0;
         min_ref   <= '0;
         max_value <= '0;
         max_ref   <= '0;
      end else if (init) begin
         min_value <= '1;
         min_ref   <= '0;
         max_value <= '0;
         max_ref   <= '0;
      end else if (upd) begin
         if (upd_value < min_value) begin
            min_value <= upd_value;
            min_ref   <= upd_ref;
         end
         if (upd_value > max_value) begin
            max_value <= upd_value;
            max_ref   <= upd_ref;
         end
      end
   end
endmodule

// File: rtl/hsid_x_scheduler.sv
// rtl/hsid_x_scheduler.sv - sequences one HSpecID-X run: fetches band pairs, feeds the MSE datapath, folds extrema
module hsid_x_scheduler
   import hsid_pkg::*;
#(
   parameter int WORD_WIDTH        = 32,
   parameter int HSP_BANDS_WIDTH   = 8,
   parameter int HSP_LIBRARY_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         clear,
   input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
   input  logic [HSP_BANDS_WIDTH-1:0]   pixel_bands,
   input  logic [WORD_WIDTH-1:0]        captured_pixel_addr,
   input  logic [WORD_WIDTH-1:0]        library_pixel_addr,
   output logic                         idle,
   output logic                         ready,
   output logic                         done,
   output logic                         error,
   output logic                         cancelled,
   hsid_x_scheduler_if.master           bus,
   output logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref,
   output logic [WORD_WIDTH-1:0]        mse_min_value,
   output logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref,
   output logic [WORD_WIDTH-1:0]        mse_max_value
);
   localparam logic [2:0] S_IDLE     = HSID_IDLE;
   localparam logic [2:0] S_CAP_REQ  = HSID_CAP_REQ;
   localparam logic [2:0] S_CAP_WAIT = HSID_CAP_WAIT;
   localparam logic [2:0] S_LIB_REQ  = HSID_LIB_REQ;
   localparam logic [2:0] S_LIB_WAIT = HSID_LIB_WAIT;
   localparam logic [2:0] S_EMIT     = HSID_EMIT;
   localparam logic [2:0] S_DRAIN    = HSID_DRAIN;
   localparam logic [2:0] S_CANCEL   = HSID_CANCEL;

   logic [2:0]                   state;
   logic [HSP_BANDS_WIDTH-1:0]   b, bands_n;
   logic [HSP_LIBRARY_WIDTH-1:0] i, lib_n, results;
   logic [WORD_WIDTH-1:0]        cap_base, lib_base, cap_word, lib_word, word_idx;
   logic busy, is_req, is_wait, in_flight, zero_cfg, run_start, last_band, last_pixel;

   assign busy       = (state != S_IDLE);
   assign is_req     = (state == S_CAP_REQ) || (state == S_LIB_REQ);
   assign is_wait    = (state == S_CAP_WAIT) || (state == S_LIB_WAIT);
   // A granted read must be allowed to return before the run can be abandoned.
   assign in_flight  = (is_req && bus.mem_gnt) || (is_wait && !bus.mem_rvalid);
   assign zero_cfg   = (library_size == '0) || (pixel_bands == '0);
   assign run_start  = !busy && start && !clear && !zero_cfg;
   assign last_band  = (b == bands_n - HSP_BANDS_WIDTH'(1));
   assign last_pixel = (i == lib_n - HSP_LIBRARY_WIDTH'(1));

   assign idle  = !busy;
   assign ready = idle && !start && !clear;

   assign word_idx = (state == S_CAP_REQ) ? WORD_WIDTH'(b)
                   : WORD_WIDTH'(i) * WORD_WIDTH'(bands_n) + WORD_WIDTH'(b);
   assign bus.mem_req  = is_req;
   assign bus.mem_addr = is_req ? ((state == S_CAP_REQ) ? cap_base : lib_base)
                                  + word_idx * WORD_WIDTH'(HSID_WORD_BYTES)
                                : '0;

   assign bus.dp_valid     = (state == S_EMIT);
   assign bus.dp_captured  = cap_word;
   assign bus.dp_library   = lib_word;
   assign bus.dp_last_band = (state == S_EMIT) && last_band;
   assign bus.dp_pixel_ref = i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         b         <= '0;
         i         <= '0;
         results   <= '0;
         bands_n   <= '0;
         lib_n     <= '0;
         cap_base  <= '0;
         lib_base  <= '0;
         cap_word  <= '0;
         lib_word  <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
         cancelled <= 1'b0;
      end else begin
         done      <= 1'b0;
         error     <= 1'b0;
         cancelled <= 1'b0;
         if (busy && bus.dp_mse_valid) results <= results + HSP_LIBRARY_WIDTH'(1);
         if (clear && busy && state != S_CANCEL) begin
            if (in_flight) begin
               state <= S_CANCEL;
            end else begin
               state     <= S_IDLE;
               cancelled <= 1'b1;
            end
         end else begin
            case (state)
               S_IDLE: if (start && !clear) begin
                  if (zero_cfg) begin
                     error <= 1'b1;
                  end else begin
                     bands_n  <= pixel_bands;
                     lib_n    <= library_size;
                     cap_base <= captured_pixel_addr;
                     lib_base <= library_pixel_addr;
                     b        <= '0;
                     i        <= '0;
                     results  <= '0;
                     state    <= S_CAP_REQ;
                  end
               end
               S_CAP_REQ: if (bus.mem_gnt) state <= S_CAP_WAIT;
               S_CAP_WAIT: if (bus.mem_rvalid) begin
                  if (bus.mem_err) begin
                     error <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     cap_word <= bus.mem_rdata;
                     state    <= S_LIB_REQ;
                  end
               end
               S_LIB_REQ: if (bus.mem_gnt) state <= S_LIB_WAIT;
               S_LIB_WAIT: if (bus.mem_rvalid) begin
                  if (bus.mem_err) begin
                     error <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     lib_word <= bus.mem_rdata;
                     state    <= S_EMIT;
                  end
               end
               S_EMIT: begin
                  if (last_band) begin
                     b <= '0;
                     if (last_pixel) begin
                        state <= S_DRAIN;
                     end else begin
                        i     <= i + HSP_LIBRARY_WIDTH'(1);
                        state <= S_CAP_REQ;
                     end
                  end else begin
                     b     <= b + HSP_BANDS_WIDTH'(1);
                     state <= S_CAP_REQ;
                  end
               end
               S_DRAIN: if (results == lib_n) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
               S_CANCEL: if (bus.mem_rvalid) begin
                  cancelled <= 1'b1;
                  state     <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   hsid_x_minmax #(.WW(WORD_WIDTH), .HLW(HSP_LIBRARY_WIDTH)) u_minmax (
      .clk       (clk),
      .rst       (rst),
      .init      (run_start),
      .clr       (clear),
      .upd       (busy && bus.dp_mse_valid),
      .upd_value (bus.dp_mse_value),
      .upd_ref   (bus.dp_mse_ref),
      .min_value (mse_min_value),
      .min_ref   (mse_min_ref),
      .max_value (mse_max_value),
      .max_ref   (mse_max_ref)
   );
endmodule

// File: tb/tb_hsid_x_scheduler.sv
// tb/tb_hsid_x_scheduler.sv - self-checking bench for hsid_x_scheduler with memory and datapath models
module tb_hsid_x_scheduler;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, clear = 1'b0;
   logic [7:0]  library_size = '0, pixel_bands = '0;
   logic [31:0] captured_pixel_addr = '0, library_pixel_addr = '0;
   logic        idle, ready, done, error, cancelled;
   logic [7:0]  mse_min_ref, mse_max_ref;
   logic [31:0] mse_min_value, mse_max_value;

   hsid_x_scheduler_if #(.WW(32), .HLW(8)) bus ();

   hsid_x_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear),
      .library_size(library_size), .pixel_bands(pixel_bands),
      .captured_pixel_addr(captured_pixel_addr), .library_pixel_addr(library_pixel_addr),
      .idle(idle), .ready(ready), .done(done), .error(error), .cancelled(cancelled),
      .bus(bus),
      .mse_min_ref(mse_min_ref), .mse_min_value(mse_min_value),
      .mse_max_ref(mse_max_ref), .mse_max_value(mse_max_value)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] c; logic [31:0] l; logic last; logic [7:0] pref; } dp_t;
   typedef struct { int pref; int due; } res_t;

   logic [31:0] rlog[$];
   dp_t         dplog[$];
   res_t        resq[$];
   int          mse_vals[16];
   int gnt_delay = 0, rv_delay = 0, err_idx = -1, nread = 0;
   int cyc = 0, req_age = 0, wait_left = 0;
   bit pend = 0, hs_prev = 0, stab_en = 0, prev_wait_req = 0;
   logic [31:0] hs_addr = '0, paddr = '0, prev_addr = '0;
   int cnt_done = 0, cnt_err = 0, cnt_can = 0, cnt_req = 0, stab_err = 0, excl_err = 0;
   int passed = 0, total = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // Memory slave (one outstanding read, programmable grant/return delay) plus datapath stub.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         pend = 0; hs_prev = 0; req_age = 0; prev_wait_req = 0; resq.delete();
         bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_err = 0; bus.mem_rdata = '0;
         bus.dp_mse_valid = 0; bus.dp_mse_value = '0; bus.dp_mse_ref = '0;
      end else begin
         if (stab_en && prev_wait_req && !(bus.mem_req && bus.mem_addr == prev_addr)) stab_err++;
         bus.mem_rvalid = 0; bus.mem_err = 0; bus.mem_rdata = '0;
         if (hs_prev) begin
            pend = 1; wait_left = rv_delay; paddr = hs_addr; rlog.push_back(hs_addr);
         end
         if (pend) begin
            if (wait_left == 0) begin
               bus.mem_rvalid = 1; bus.mem_rdata = mem_word(paddr);
               bus.mem_err = (nread == err_idx); nread++; pend = 0;
            end else wait_left--;
         end
         if (bus.mem_req && !pend) begin
            bus.mem_gnt = (req_age >= gnt_delay); req_age++;
         end else begin
            bus.mem_gnt = 0; req_age = 0;
         end
         hs_prev = bus.mem_req && bus.mem_gnt; hs_addr = bus.mem_addr;
         prev_wait_req = bus.mem_req && !bus.mem_gnt; prev_addr = bus.mem_addr;
         if (bus.mem_req) cnt_req++;
         if (bus.dp_valid) begin
            dplog.push_back('{bus.dp_captured, bus.dp_library, bus.dp_last_band, bus.dp_pixel_ref});
            if (bus.dp_last_band) resq.push_back('{int'(bus.dp_pixel_ref), cyc + 2});
         end
         bus.dp_mse_valid = 0;
         if (resq.size() > 0 && resq[0].due <= cyc) begin
            bus.dp_mse_valid = 1;
            bus.dp_mse_ref   = 8'(resq[0].pref);
            bus.dp_mse_value = 32'(mse_vals[resq[0].pref]);
            void'(resq.pop_front());
         end
         cnt_done += int'(done); cnt_err += int'(error); cnt_can += int'(cancelled);
         if (int'(done) + int'(error) + int'(cancelled) > 1) excl_err++;
      end
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clr_logs();
      rlog.delete(); dplog.delete(); nread = 0;
      cnt_done = 0; cnt_err = 0; cnt_can = 0; cnt_req = 0;
   endtask

   task automatic run(input int nb, input int nl, input logic [31:0] ca, input logic [31:0] la, input int budget);
      pixel_bands = 8'(nb); library_size = 8'(nl);
      captured_pixel_addr = ca; library_pixel_addr = la;
      clr_logs();
      start = 1; tick(); start = 0;
      for (int k = 0; k < budget && (cnt_done + cnt_err + cnt_can) == 0; k++) tick();
   endtask

   task automatic check_run(input string tag, input int nb, input int nl, input logic [31:0] ca, input logic [31:0] la);
      int bad, k;
      logic [31:0] mnv, mxv;
      int mnr, mxr;
      dp_t e;
      bad = 0;
      chk({tag, "_reads_n"}, 64'(rlog.size()), 64'(2 * nb * nl));
      for (int p = 0; p < nl; p++)
         for (int bb = 0; bb < nb; bb++) begin
            k = p * nb + bb;
            if (2 * k + 1 < rlog.size()) begin
               if (rlog[2*k]   !== ca + 32'(4 * bb)) bad++;
               if (rlog[2*k+1] !== la + 32'(4 * k))  bad++;
            end
         end
      chk({tag, "_reads_order"}, 64'(bad), 64'd0);
      bad = 0;
      chk({tag, "_dp_n"}, 64'(dplog.size()), 64'(nb * nl));
      for (int p = 0; p < nl; p++)
         for (int bb = 0; bb < nb; bb++) begin
            k = p * nb + bb;
            if (k < dplog.size()) begin
               e = dplog[k];
               if (e.c !== mem_word(ca + 32'(4 * bb)) || e.l !== mem_word(la + 32'(4 * k)) ||
                   e.last !== (bb == nb - 1) || e.pref !== 8'(p)) bad++;
            end
         end
      chk({tag, "_dp_data"}, 64'(bad), 64'd0);
      // Extrema: smallest/largest value, reference = first pixel holding it.
      mnv = '1; mxv = '0;
      foreach (mse_vals[p]) if (p < nl) begin
         if (32'(mse_vals[p]) < mnv) mnv = 32'(mse_vals[p]);
         if (32'(mse_vals[p]) > mxv) mxv = 32'(mse_vals[p]);
      end
      mnr = -1; mxr = -1;
      for (int p = 0; p < nl; p++) begin
         if (mnr < 0 && 32'(mse_vals[p]) == mnv) mnr = p;
         if (mxr < 0 && 32'(mse_vals[p]) == mxv) mxr = p;
      end
      if (mxv == 0) mxr = 0;
      chk({tag, "_min_value"}, 64'(mse_min_value), 64'(mnv));
      chk({tag, "_min_ref"},   64'(mse_min_ref),   64'(mnr));
      chk({tag, "_max_value"}, 64'(mse_max_value), 64'(mxv));
      chk({tag, "_max_ref"},   64'(mse_max_ref),   64'(mxr));
      chk({tag, "_done_cnt"},  64'(cnt_done),      64'd1);
      chk({tag, "_idle"},      64'(idle),          64'd1);
   endtask

   initial begin
      int nb, nl;
      logic [31:0] ca, la;
      repeat (3) tick();
      rst = 0; tick();
      chk("reset_status", {59'd0, idle, ready, done, error, cancelled}, 64'b11000);
      chk("reset_bus", {61'd0, bus.mem_req, bus.dp_valid, bus.dp_last_band}, 64'd0);
      chk("reset_mse", {mse_min_value, mse_max_value}, 64'd0);
      chk("reset_refs", {mse_min_ref, mse_max_ref}, 64'd0);

      mse_vals[0] = 10; mse_vals[1] = 4;
      run(3, 2, 32'h1000, 32'h2000, 300);
      check_run("basic", 3, 2, 32'h1000, 32'h2000);

      gnt_delay = 3; stab_en = 1; stab_err = 0;
      mse_vals[0] = 5; mse_vals[1] = 9;
      run(2, 2, 32'h40, 32'h8000_0000, 400);
      check_run("gnt_delay", 2, 2, 32'h40, 32'h8000_0000);
      chk("gnt_hold_stable", 64'(stab_err), 64'd0);
      gnt_delay = 0; stab_en = 0;

      library_size = 0; pixel_bands = 3; clr_logs();
      start = 1; #1;
      chk("ready_with_start", 64'(ready), 64'd0);
      tick(); start = 0;
      chk("zero_lib_error", {62'd0, error, idle}, 64'b11);
      repeat (4) tick();
      chk("zero_lib_noreq", 64'(cnt_req), 64'd0);
      chk("zero_lib_err_cnt", 64'(cnt_err), 64'd1);
      run(0, 3, 32'h0, 32'h100, 10);
      chk("zero_bands", {32'(cnt_err), 32'(cnt_req)}, {32'd1, 32'd0});

      rv_delay = 4; pixel_bands = 2; library_size = 2; clr_logs();
      start = 1; tick(); start = 0;
      for (int k = 0; k < 10 && rlog.size() == 0; k++) tick();
      clear = 1; tick(); clear = 0;
      chk("cancel_waiting", {62'd0, idle, cancelled}, 64'd0);
      for (int k = 0; k < 20 && cnt_can == 0; k++) tick();
      chk("cancel_pulse", 64'(cnt_can), 64'd1);
      chk("cancel_reads", 64'(rlog.size()), 64'd1);
      chk("cancel_idle_nodone", {31'd0, idle, 32'(cnt_done)}, {32'd1, 32'd0});
      chk("cancel_mse_zero", 64'(mse_min_value), 64'd0);
      rv_delay = 0;

      err_idx = 3;
      run(3, 2, 32'h3000, 32'h4000, 200);
      chk("err_pulse_idle", {62'd0, error, idle}, 64'b11);
      chk("err_counts", {32'(cnt_err), 32'(cnt_done)}, {32'd1, 32'd0});
      chk("err_reads", 64'(rlog.size()), 64'd4);
      err_idx = -1;

      mse_vals[0] = 7; mse_vals[1] = 7;
      run(1, 2, 32'h500, 32'h600, 200);
      check_run("ties", 1, 2, 32'h500, 32'h600);

      clr_logs(); start = 1; clear = 1; tick(); start = 0; clear = 0;
      repeat (5) tick();
      chk("start_clear_noreq", 64'(cnt_req), 64'd0);
      chk("start_clear_idle", 64'(idle), 64'd1);
      chk("start_clear_mse", {mse_max_value, 24'd0, mse_max_ref}, 64'd0);
      chk("start_clear_pulses", 64'(cnt_done + cnt_err + cnt_can), 64'd0);

      for (int r = 0; r < 6; r++) begin
         nb = int'($urandom_range(1, 4)); nl = int'($urandom_range(1, 4));
         ca = $urandom & 32'hFFFF_FFFC; la = $urandom & 32'hFFFF_FFFC;
         gnt_delay = int'($urandom_range(0, 2)); rv_delay = int'($urandom_range(0, 2));
         for (int p = 0; p < 16; p++) mse_vals[p] = int'($urandom_range(0, 20));
         run(nb, nl, ca, la, 2000);
         check_run($sformatf("rand%0d", r), nb, nl, ca, la);
      end
      gnt_delay = 0; rv_delay = 0;

      run(2, 2, 32'h700, 32'h800, 3);
      rst = 1; #1;
      chk("async_rst_req", {62'd0, bus.mem_req, idle}, 64'b01);
      chk("async_rst_mse", 64'(mse_min_value), 64'd0);
      tick(); rst = 0; tick();
      chk("pulse_exclusive", 64'(excl_err), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
